// File: rtl/pifo_pkg.sv
// pifo_pkg: shared definitions for the PIFO and its enqueue-side rank stage.
//   - default sizing constants and the width derivations built on them
//   - PifoEntry: {data, prio} entry as stored by the PIFO
//   - sat_add:   unsigned add clipped to a ceiling (ranks must never wrap)
package pifo_pkg;

  localparam int unsigned NUM_FLOWS_DEF    = 16;
  localparam int unsigned MAX_PRIORITY_DEF = 256;
  localparam int unsigned DATA_WIDTH_DEF   = 8;
  localparam int unsigned LEN_WIDTH_DEF    = 8;
  localparam int unsigned FLOW_WIDTH_DEF   = $clog2(NUM_FLOWS_DEF);
  localparam int unsigned PRIO_WIDTH_DEF   = $clog2(MAX_PRIORITY_DEF);

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] data;
    logic [PRIO_WIDTH_DEF-1:0] prio;
  } PifoEntry;

  // Sum is formed one bit wider than the operands so the clip is exact.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, max_v}) ? max_v : s[31:0];
  endfunction

endpackage

// File: rtl/pifo_flow_table.sv
// pifo_flow_table: DEPTH x WIDTH per-flow register array.
// Ports:
//   clk      - clock
//   clear_i  - synchronous clear of every entry (active high)
//   raddr_i  - combinational read address; out-of-range reads return 0
//   rdata_o  - read data
//   we_i     - synchronous write enable; out-of-range writes are dropped
//   waddr_i  - write address
//   wdata_i  - write data
module pifo_flow_table #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             rd_ok;
  logic             wr_ok;

  assign rd_ok   = ({1'b0, raddr_i} < (AW+1)'(DEPTH));
  assign wr_ok   = ({1'b0, waddr_i} < (AW+1)'(DEPTH));
  assign rdata_o = rd_ok ? mem_q[raddr_i] : '0;

  always_ff @(posedge clk) begin
    if (clear_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i[AW-1:0]] <= '0;
      end
    end else if (we_i && wr_ok) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/pifo_stfq_rank.sv
// pifo_stfq_rank: Start-Time Fair Queueing rank stage in front of the PIFO.
//   rank = max(vtime, finish[flow]); finish[flow] <= sat(rank + len).
//   vtime follows the rank of each packet popped from the PIFO.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   i__pkt_*/o__pkt_ready    - upstream packet valid/ready
//   o__data_out_*            - ranked {data, prio} towards PIFO enqueue
//   i__data_out_ready        - PIFO enqueue ready
//   i__deq_valid/_priority   - PIFO pop notification and popped rank
//   i__clear_all             - flush table, vtime and output register
// Optional macro PIFO_STFQ_WEIGHT_EN adds a per-flow length shift table
// written through i__cfg_valid/i__cfg_flow_id/i__cfg_wshift.
module pifo_stfq_rank
  import pifo_pkg::*;
#(
  parameter  int unsigned NUM_FLOWS    = NUM_FLOWS_DEF,
  parameter  int unsigned MAX_PRIORITY = MAX_PRIORITY_DEF,
  parameter  int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter  int unsigned LEN_WIDTH    = LEN_WIDTH_DEF,
  localparam int unsigned FLOW_WIDTH   = $clog2(NUM_FLOWS),
  localparam int unsigned PRIO_WIDTH   = $clog2(MAX_PRIORITY)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i__pkt_valid,
  input  logic [FLOW_WIDTH-1:0] i__pkt_flow_id,
  input  logic [LEN_WIDTH-1:0]  i__pkt_len,
  input  logic [DATA_WIDTH-1:0] i__pkt_data,
  output logic                  o__pkt_ready,
  output logic                  o__data_out_valid,
  output logic [PRIO_WIDTH-1:0] o__data_out_priority,
  output logic [DATA_WIDTH-1:0] o__data_out,
  input  logic                  i__data_out_ready,
  input  logic                  i__deq_valid,
  input  logic [PRIO_WIDTH-1:0] i__deq_priority,
`ifdef PIFO_STFQ_WEIGHT_EN
  input  logic                  i__cfg_valid,
  input  logic [FLOW_WIDTH-1:0] i__cfg_flow_id,
  input  logic [2:0]            i__cfg_wshift,
`endif
  input  logic                  i__clear_all
);

  logic                  valid_q, valid_d;
  logic [PRIO_WIDTH-1:0] prio_q, prio_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [PRIO_WIDTH-1:0] vtime_q, vtime_d;

  logic                  accept;
  logic                  flush;
  logic [PRIO_WIDTH-1:0] fin_rd;
  logic [PRIO_WIDTH-1:0] start;
  logic [PRIO_WIDTH-1:0] fin;
  logic [LEN_WIDTH-1:0]  len_eff;

  assign flush        = reset | i__clear_all;
  assign o__pkt_ready = (~valid_q | i__data_out_ready) & ~reset;
  assign accept       = i__pkt_valid & o__pkt_ready;

  // Out-of-range flows read 0 and never write, so their rank is vtime.
  pifo_flow_table #(
    .DEPTH (NUM_FLOWS),
    .WIDTH (PRIO_WIDTH)
  ) u_finish (
    .clk     (clk),
    .clear_i (flush),
    .raddr_i (i__pkt_flow_id),
    .rdata_o (fin_rd),
    .we_i    (accept & ~i__clear_all),
    .waddr_i (i__pkt_flow_id),
    .wdata_i (fin)
  );

`ifdef PIFO_STFQ_WEIGHT_EN
  logic [2:0] wshift_rd;

  // Same-cycle config write lands on the edge, so the packet sees the old shift.
  pifo_flow_table #(
    .DEPTH (NUM_FLOWS),
    .WIDTH (3)
  ) u_wshift (
    .clk     (clk),
    .clear_i (flush),
    .raddr_i (i__pkt_flow_id),
    .rdata_o (wshift_rd),
    .we_i    (i__cfg_valid & ~i__clear_all),
    .waddr_i (i__cfg_flow_id),
    .wdata_i (i__cfg_wshift)
  );

  assign len_eff = i__pkt_len >> wshift_rd;
`else
  assign len_eff = i__pkt_len;
`endif

  always_comb begin
    start = (vtime_q > fin_rd) ? vtime_q : fin_rd;
    fin   = PRIO_WIDTH'(sat_add(32'(start), 32'(len_eff), 32'(MAX_PRIORITY - 1)));
  end

  always_comb begin
    valid_d = valid_q;
    prio_d  = prio_q;
    data_d  = data_q;
    vtime_d = vtime_q;
    if (accept) begin
      valid_d = 1'b1;
      prio_d  = start;
      data_d  = i__pkt_data;
    end else if (i__data_out_ready) begin
      valid_d = 1'b0;
    end
    if (i__deq_valid && (i__deq_priority > vtime_q)) begin
      vtime_d = i__deq_priority;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      valid_q <= 1'b0;
      prio_q  <= '0;
      data_q  <= '0;
      vtime_q <= '0;
    end else begin
      valid_q <= valid_d;
      prio_q  <= prio_d;
      data_q  <= data_d;
      vtime_q <= vtime_d;
    end
  end

  assign o__data_out_valid    = valid_q;
  assign o__data_out_priority = prio_q;
  assign o__data_out          = data_q;

endmodule
